// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: valid/ready word load, one bit per clock, one-word holding buffer.
// state | meaning: IDLE = shifter empty ; SHIFT = emitting bit bit_cnt of the current word
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             buf_valid_q, buf_valid_d;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  assign load_ready = !buf_valid_q;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (bit_cnt_q == LAST);
  assign shifted    = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};

  assign ser_valid  = (state_q == SHIFT);
  assign ser_out    = ser_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign word_done  = ser_valid && last_bit;
  assign busy       = ser_valid || buf_valid_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    buf_valid_d = buf_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (accept) begin
            hold_d      = data_in;
            buf_valid_d = 1'b1;
          end
        end else if (buf_valid_q) begin
          // load_ready is low while the buffer is full, so it can only drain here
          shreg_d     = hold_q;
          bit_cnt_d   = '0;
          buf_valid_d = 1'b0;
        end else if (accept) begin
          shreg_d   = data_in;
          bit_cnt_d = '0;
        end else begin
          shreg_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      hold_q      <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first instances share all inputs.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;

  logic lr_m, so_m, sv_m, wd_m, bs_m;
  logic lr_l, so_l, sv_l, wd_l, bs_l;
  logic lr_s, so_s, sv_s, wd_s, bs_s;
  bit   sel_lsb = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_m), .ser_out(so_m), .ser_valid(sv_m), .word_done(wd_m), .busy(bs_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(lr_l), .ser_out(so_l), .ser_valid(sv_l), .word_done(wd_l), .busy(bs_l)
  );

  assign lr_s = sel_lsb ? lr_l : lr_m;
  assign so_s = sel_lsb ? so_l : so_m;
  assign sv_s = sel_lsb ? sv_l : sv_m;
  assign wd_s = sel_lsb ? wd_l : wd_m;
  assign bs_s = sel_lsb ? bs_l : bs_m;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ser_valid"},  32'(sv_s), 32'd0);
    chk({tag, ".ser_out"},    32'(so_s), 32'd0);
    chk({tag, ".word_done"},  32'(wd_s), 32'd0);
    chk({tag, ".busy"},       32'(bs_s), 32'd0);
    chk({tag, ".load_ready"}, 32'(lr_s), 32'd1);
  endtask

  // Offers up to three words with load_valid held until each is accepted and
  // checks the serial stream exp_bits (bit 23 first) plus the handshake flags.
  task automatic stream(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input int n, input logic [23:0] exp_bits,
                        input bit lsb);
    logic [7:0] w [3];
    int  sent;
    bit  acc;
    w[0] = w0; w[1] = w1; w[2] = w2;
    sel_lsb    = lsb;
    data_in    = w[0];
    load_valid = 1'b1;
    tick();
    sent = 1;
    for (int k = 0; k < 8 * n; k++) begin
      if (sent < n) begin
        load_valid = 1'b1;
        data_in    = w[sent];
      end else begin
        load_valid = 1'b0;
        data_in    = 8'h00;
      end
      acc = load_valid && lr_s;
      chk($sformatf("%s.bit%0d.ser_out", tag, k),    32'(so_s), 32'(exp_bits[23-k]));
      chk($sformatf("%s.bit%0d.ser_valid", tag, k),  32'(sv_s), 32'd1);
      chk($sformatf("%s.bit%0d.word_done", tag, k),  32'(wd_s), 32'((k % 8) == 7));
      chk($sformatf("%s.bit%0d.load_ready", tag, k), 32'(lr_s),
          32'(((k % 8) == 0) || ((k / 8) >= (n - 1))));
      chk($sformatf("%s.bit%0d.busy", tag, k),       32'(bs_s), 32'd1);
      tick();
      if (acc) sent++;
    end
    load_valid = 1'b0;
    chk({tag, ".accepted_all"}, 32'(sent), 32'(n));
    chk_idle({tag, ".after"});
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 8'h00;
    load_valid = 1'b0;
    @(negedge clk);
    tick();
    tick();
    sel_lsb = 1'b0;
    chk_idle("reset_msb");
    sel_lsb = 1'b1;
    chk_idle("reset_lsb");
    reset = 1'b0;

    stream("single_b0", 8'hB0, 8'h00, 8'h00, 1, 24'hB00000, 1'b0);
    tick();
    stream("pair_b0_0b", 8'hB0, 8'h0B, 8'h00, 2, 24'hB00B00, 1'b0);
    stream("triple", 8'hB0, 8'h0B, 8'h5A, 3, 24'hB00B5A, 1'b0);
    stream("lsb_0d", 8'h0D, 8'h00, 8'h00, 1, 24'hB00000, 1'b1);

    // Reset in the middle of 8'hFF with a second word sitting in the buffer.
    sel_lsb    = 1'b0;
    data_in    = 8'hFF;
    load_valid = 1'b1;
    tick();
    data_in    = 8'h33;
    tick();
    load_valid = 1'b0;
    data_in    = 8'h00;
    tick();
    tick();
    chk("midreset.bit3.ser_out",    32'(so_s), 32'd1);
    chk("midreset.bit3.busy",       32'(bs_s), 32'd1);
    chk("midreset.bit3.load_ready", 32'(lr_s), 32'd0);
    reset = 1'b1;
    tick();
    chk_idle("midreset.after_edge");
    reset = 1'b0;
    tick();
    chk_idle("midreset.quiet");
    stream("post_reset_b0", 8'hB0, 8'h00, 8'h00, 1, 24'hB00000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
